// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Two-stage pipelined execute ALU for the LEGv8 datapath.
//   S1 registers the operand bundle (a, b, ctrl). S2 computes the result and
//   the NZCV-style flags from the S1 registers and registers them. Every
//   output comes straight from an S2 register. Valid/ready handshaking on both
//   sides lets the stage hold its contents under backpressure.
//
// Ports:
//   CLK          rising-edge clock
//   Reset        synchronous active-high reset
//   in_valid     operand bundle valid
//   in_ready     stage can accept a bundle this cycle (combinational)
//   in_a, in_b   operands (WIDTH bits)
//   in_ctrl      4-bit ALU control code
//   out_valid    result bundle valid
//   out_ready    downstream accepts the result
//   out_result   ALU result (WIDTH bits)
//   out_zero     result == 0
//   out_neg      result sign bit
//   out_carry    carry out (ADD/SUB only)
//   out_ovf      signed overflow (ADD/SUB only)
//   out_illegal  in_ctrl was not a defined code
// -----------------------------------------------------------------------------
module alu_exec_stage #(
   parameter int WIDTH = 64
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_illegal
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_PASSB = 4'b0111;
   localparam logic [3:0] OP_NOR   = 4'b1100;

   // S1 registers
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [3:0]       s1_ctrl_q, s1_ctrl_d;

   // S2 registers
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_result_q, s2_result_d;
   logic             s2_zero_q, s2_zero_d;
   logic             s2_neg_q, s2_neg_d;
   logic             s2_carry_q, s2_carry_d;
   logic             s2_ovf_q, s2_ovf_d;
   logic             s2_illegal_q, s2_illegal_d;

   logic             s1_ready;
   logic             s2_ready;

   // ALU combinational results from the S1 registers
   logic [WIDTH-1:0] alu_op_b;
   logic             alu_cin;
   logic [WIDTH:0]   alu_sum;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             alu_ovf;
   logic             alu_illegal;

   assign s2_ready = !s2_valid_q || out_ready;
   assign s1_ready = !s1_valid_q || s2_ready;
   assign in_ready = s1_ready;

   always_comb begin
      // SUB reuses the adder as A + ~B + 1 so its carry means "no borrow".
      alu_op_b    = (s1_ctrl_q == OP_SUB) ? ~s1_b_q : s1_b_q;
      alu_cin     = (s1_ctrl_q == OP_SUB);
      alu_sum     = {1'b0, s1_a_q} + {1'b0, alu_op_b} + {{WIDTH{1'b0}}, alu_cin};
      alu_result  = '0;
      alu_carry   = 1'b0;
      alu_ovf     = 1'b0;
      alu_illegal = 1'b0;
      case (s1_ctrl_q)
         OP_AND:   alu_result = s1_a_q & s1_b_q;
         OP_OR:    alu_result = s1_a_q | s1_b_q;
         OP_NOR:   alu_result = ~(s1_a_q | s1_b_q);
         OP_PASSB: alu_result = s1_b_q;
         OP_ADD, OP_SUB: begin
            alu_result = alu_sum[WIDTH-1:0];
            alu_carry  = alu_sum[WIDTH];
            // Overflow when the effective addends share a sign that the
            // result does not; for SUB the effective addend is ~B.
            alu_ovf    = (s1_a_q[WIDTH-1] == alu_op_b[WIDTH-1]) &&
                         (alu_sum[WIDTH-1] != s1_a_q[WIDTH-1]);
         end
         default:  alu_illegal = 1'b1;
      endcase
   end

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      s1_ctrl_d    = s1_ctrl_q;
      s2_valid_d   = s2_valid_q;
      s2_result_d  = s2_result_q;
      s2_zero_d    = s2_zero_q;
      s2_neg_d     = s2_neg_q;
      s2_carry_d   = s2_carry_q;
      s2_ovf_d     = s2_ovf_q;
      s2_illegal_d = s2_illegal_q;

      // S1 is either empty or draining into S2 whenever s1_ready is high.
      if (s1_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d    = in_a;
            s1_b_d    = in_b;
            s1_ctrl_d = in_ctrl;
         end
      end

      if (s2_ready) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_result_d  = alu_result;
            s2_zero_d    = !alu_illegal && (alu_result == '0);
            s2_neg_d     = !alu_illegal && alu_result[WIDTH-1];
            s2_carry_d   = alu_carry;
            s2_ovf_d     = alu_ovf;
            s2_illegal_d = alu_illegal;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_ctrl_q    <= '0;
         s2_valid_q   <= 1'b0;
         s2_result_q  <= '0;
         s2_zero_q    <= 1'b0;
         s2_neg_q     <= 1'b0;
         s2_carry_q   <= 1'b0;
         s2_ovf_q     <= 1'b0;
         s2_illegal_q <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_ctrl_q    <= s1_ctrl_d;
         s2_valid_q   <= s2_valid_d;
         s2_result_q  <= s2_result_d;
         s2_zero_q    <= s2_zero_d;
         s2_neg_q     <= s2_neg_d;
         s2_carry_q   <= s2_carry_d;
         s2_ovf_q     <= s2_ovf_d;
         s2_illegal_q <= s2_illegal_d;
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_result  = s2_result_q;
   assign out_zero    = s2_zero_q;
   assign out_neg     = s2_neg_q;
   assign out_carry   = s2_carry_q;
   assign out_ovf     = s2_ovf_q;
   assign out_illegal = s2_illegal_q;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Pipelined execute-stage ALU for the LEGv8 datapath.
- Consumes the 4-bit ALU control code from the ALU control decoder plus two operands, and produces a result and NZCV-style flags.
- Two internal register stages with valid/ready backpressure, so it can sit between decode and memory/writeback in the pipelined processor build.

Parameters:
- WIDTH, 64, operand/result width in bits (minimum 2).

Ports:
- CLK  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  stage can accept a bundle this cycle
- in_a  input  WIDTH  operand A (register Rn)
- in_b  input  WIDTH  operand B (register Rm or sign-extended immediate)
- in_ctrl  input  4  ALU control code
- out_valid  output  1  result bundle valid
- out_ready  input  1  downstream accepts the result
- out_result  output  WIDTH  ALU result
- out_zero  output  1  result == 0
- out_neg  output  1  result[WIDTH-1]
- out_carry  output  1  carry out (ADD/SUB only)
- out_ovf  output  1  signed overflow (ADD/SUB only)
- out_illegal  output  1  in_ctrl was not a defined code

Behaviour:
- Control codes:
  - 0000 AND: A & B
  - 0001 OR: A | B
  - 0010 ADD: A + B
  - 0110 SUB: A + ~B + 1
  - 0111 PASSB: result = B (CBZ test)
  - 1100 NOR: ~(A | B)
  - All other codes are illegal.
- Carry:
  - ADD: bit WIDTH of the (WIDTH+1)-bit unsigned sum.
  - SUB: carry of A + ~B + 1, so 1 means no borrow.
  - All other ops: 0.
- Overflow:
  - ADD: A and B share a sign and the result sign differs.
  - SUB: A and B signs differ and the result sign differs from A.
  - All other ops: 0.
- Zero and negative are computed from the result for every legal op.
- Illegal code: result = 0, zero = neg = carry = ovf = 0, illegal = 1. The bundle still flows through the pipeline and is not dropped.
- Pipeline structure:
  - Stage 1 (S1) registers a, b, ctrl and a valid bit.
  - Stage 2 (S2) computes from the S1 registers and registers result, flags, illegal and a valid bit.
  - All out_* signals come directly from S2 registers; nothing combinational reaches the outputs.
- Handshake:
  - s2_ready = !s2_valid | out_ready
  - s1_ready = !s1_valid | s2_ready
  - in_ready = s1_ready (combinational; it may depend on out_ready)
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Latency: a bundle accepted at edge N appears on the outputs after edge N+1, i.e. 2 cycles, when there is no backpressure.
- Throughput: 1 bundle per cycle when out_ready is held high.
- Stall:
  - While out_valid & !out_ready, every out_* signal holds stable.
  - S1 holds when full; in_ready deasserts only when both stages are full and out_ready = 0.
- Simultaneous events:
  - A full pipeline with out_ready = 1 accepts a new input in the same cycle it emits; no bubble is inserted.
  - An empty S2 accepts S1 regardless of out_ready.
- Data stability: S1/S2 data registers load only on their advance condition. When a stage is invalid its data contents are don't-care, but the flags seen on a valid output are always consistent with out_result.
- Reset:
  - s1_valid = s2_valid = 0, so out_valid = 0 and in_ready = 1 in the cycle after reset.
  - out_result = 0, all flags = 0, out_illegal = 0.
  - Reset mid-operation discards all in-flight bundles. Inputs presented during a Reset cycle are not accepted.
- Arithmetic wraps modulo 2^WIDTH. There is no saturation.

Test Plan:
- Reset, then ADD a=5, b=7, out_ready=1:
  - out_valid rises 2 cycles after acceptance.
  - result = 12, zero = 0, carry = 0, ovf = 0.
- SUB a=3, b=3:
  - result = 0, zero = 1, carry = 1.
- SUB a=0, b=1:
  - result = 0xFFFF_FFFF_FFFF_FFFF, neg = 1, carry = 0, ovf = 0.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1:
  - result = 0x8000_0000_0000_0000, ovf = 1, neg = 1.
- ADD a=all-ones, b=1:
  - result = 0, carry = 1, zero = 1.
- Logic ops and illegal code, a=0xF0, b=0x3C:
  - AND → 0x30.
  - OR → 0xFC.
  - NOR → ~0xFC.
  - PASSB with b=0 → zero = 1.
  - ctrl = 0011 → illegal = 1, result = 0, zero = 0.
- Backpressure: stream 4 ADDs with out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts.
  - Outputs stay frozen while stalled.
  - After out_ready=1, results emerge in order with no loss or duplication.
  - Assert Reset mid-stream: out_valid = 0 next cycle and no stale results emerge afterwards.
